// File: rtl/serial_add_pkg.sv
// Shared types and helpers for the serial two-bits-per-cycle adder controller.
package serial_add_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Step counter width: clog2(WIDTH/2), never narrower than one bit.
  function automatic int cnt_width(input int width);
    int w;
    w = $clog2(width / 2);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/add2_slice.sv
// Combinational 2-bit ripple adder made of two full-adder stages.
module add2_slice (
  input  logic [1:0] x,
  input  logic [1:0] y,
  input  logic       ci,
  output logic [1:0] s,
  output logic       co
);

  logic c1;

  assign s[0] = x[0] ^ y[0] ^ ci;
  assign c1   = (x[0] & y[0]) | (ci & (x[0] ^ y[0]));
  assign s[1] = x[1] ^ y[1] ^ c1;
  assign co   = (x[1] & y[1]) | (c1 & (x[1] ^ y[1]));

endmodule

// File: rtl/serial_add_ctrl.sv
// Serial WIDTH-bit adder: one shared 2-bit slice, result WIDTH/2 cycles after acceptance.
// One operation in flight; new operands only in IDLE. Signed overflow output with SERIAL_ADD_OVF_EN.
module serial_add_ctrl
  import serial_add_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
`ifdef SERIAL_ADD_OVF_EN
  output logic             ovf,
`endif
  output logic             busy
);

  localparam int             CW   = cnt_width(WIDTH);
  localparam logic [CW-1:0]  LAST = CW'(WIDTH / 2 - 1);

  if (((WIDTH % 2) != 0) || (WIDTH < 2)) begin : g_bad_width
    $fatal(1, "serial_add_ctrl: WIDTH must be even and >= 2");
  end

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_sh_q, a_sh_d;
  logic [WIDTH-1:0] b_sh_q, b_sh_d;
  logic [WIDTH-1:0] sum_sh_q, sum_sh_d;
  logic             carry_q, carry_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             cout_q, cout_d;
  logic             in_ready_q, in_ready_d;
  logic             out_valid_q, out_valid_d;
  logic             busy_q, busy_d;
`ifdef SERIAL_ADD_OVF_EN
  logic             sa_q, sa_d;
  logic             sb_q, sb_d;
  logic             ovf_q, ovf_d;
`endif

  logic [1:0]       slice_s;
  logic             slice_co;
  logic [WIDTH-1:0] sum_next;
  logic             sum_sh_unused;

  add2_slice u_slice (
    .x  (a_sh_q[1:0]),
    .y  (b_sh_q[1:0]),
    .ci (carry_q),
    .s  (slice_s),
    .co (slice_co)
  );

  // The low pair of sum_sh is always the oldest step and falls off the end.
  if (WIDTH == 2) begin : g_w2
    assign sum_next = slice_s;
  end else begin : g_wn
    assign sum_next = {slice_s, sum_sh_q[WIDTH-1:2]};
  end
  assign sum_sh_unused = ^sum_sh_q[1:0];

  always_comb begin
    state_d     = state_q;
    a_sh_d      = a_sh_q;
    b_sh_d      = b_sh_q;
    sum_sh_d    = sum_sh_q;
    carry_d     = carry_q;
    cnt_d       = cnt_q;
    sum_d       = sum_q;
    cout_d      = cout_q;
    in_ready_d  = in_ready_q;
    out_valid_d = out_valid_q;
    busy_d      = busy_q;
`ifdef SERIAL_ADD_OVF_EN
    sa_d        = sa_q;
    sb_d        = sb_q;
    ovf_d       = ovf_q;
`endif
    case (state_q)
      IDLE: begin
        if (in_valid && in_ready_q) begin
          state_d    = RUN;
          a_sh_d     = a;
          b_sh_d     = b;
          carry_d    = cin;
          cnt_d      = '0;
          in_ready_d = 1'b0;
          busy_d     = 1'b1;
`ifdef SERIAL_ADD_OVF_EN
          sa_d       = a[WIDTH-1];
          sb_d       = b[WIDTH-1];
`endif
        end
      end
      RUN: begin
        a_sh_d   = a_sh_q >> 2;
        b_sh_d   = b_sh_q >> 2;
        sum_sh_d = sum_next;
        carry_d  = slice_co;
        cnt_d    = cnt_q + CW'(1);
        if (cnt_q == LAST) begin
          state_d     = DONE;
          sum_d       = sum_next;
          cout_d      = slice_co;
          out_valid_d = 1'b1;
`ifdef SERIAL_ADD_OVF_EN
          ovf_d       = (sa_q == sb_q) && (sum_next[WIDTH-1] != sa_q);
`endif
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d     = IDLE;
          out_valid_d = 1'b0;
          in_ready_d  = 1'b1;
          busy_d      = 1'b0;
        end
      end
      default: begin
        state_d     = IDLE;
        out_valid_d = 1'b0;
        in_ready_d  = 1'b1;
        busy_d      = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      a_sh_q      <= '0;
      b_sh_q      <= '0;
      sum_sh_q    <= '0;
      carry_q     <= 1'b0;
      cnt_q       <= '0;
      sum_q       <= '0;
      cout_q      <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
`ifdef SERIAL_ADD_OVF_EN
      sa_q        <= 1'b0;
      sb_q        <= 1'b0;
      ovf_q       <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      a_sh_q      <= a_sh_d;
      b_sh_q      <= b_sh_d;
      sum_sh_q    <= sum_sh_d;
      carry_q     <= carry_d;
      cnt_q       <= cnt_d;
      sum_q       <= sum_d;
      cout_q      <= cout_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      busy_q      <= busy_d;
`ifdef SERIAL_ADD_OVF_EN
      sa_q        <= sa_d;
      sb_q        <= sb_d;
      ovf_q       <= ovf_d;
`endif
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign busy      = busy_q;
  assign sum       = sum_q;
  assign cout      = cout_q;
`ifdef SERIAL_ADD_OVF_EN
  assign ovf       = ovf_q;
`endif

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Bench for serial_add_ctrl at WIDTH=8 and WIDTH=2; checks ovf too when SERIAL_ADD_OVF_EN is defined.
module tb_serial_add_ctrl;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic       in_valid8, in_ready8, out_valid8, out_ready8, cin8, cout8, busy8;
  logic [7:0] a8, b8, sum8;
  logic       in_valid2, in_ready2, out_valid2, out_ready2, cin2, cout2, busy2;
  logic [1:0] a2, b2, sum2;
`ifdef SERIAL_ADD_OVF_EN
  logic       ovf8, ovf2;
`endif

  int checks   = 0;
  int failures = 0;

  serial_add_ctrl #(.WIDTH(8)) dut8 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid8), .in_ready(in_ready8),
    .a(a8), .b(b8), .cin(cin8),
    .out_valid(out_valid8), .out_ready(out_ready8),
    .sum(sum8), .cout(cout8),
`ifdef SERIAL_ADD_OVF_EN
    .ovf(ovf8),
`endif
    .busy(busy8)
  );

  serial_add_ctrl #(.WIDTH(2)) dut2 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid2), .in_ready(in_ready2),
    .a(a2), .b(b2), .cin(cin2),
    .out_valid(out_valid2), .out_ready(out_ready2),
    .sum(sum2), .cout(cout2),
`ifdef SERIAL_ADD_OVF_EN
    .ovf(ovf2),
`endif
    .busy(busy2)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference: plain integer addition and the two's-complement overflow rule.
  function automatic logic [8:0] ref8(input logic [7:0] x, input logic [7:0] y, input logic c);
    int s;
    s = int'(x) + int'(y) + int'(c);
    return 9'(s);
  endfunction

  function automatic logic ovf_ref8(input logic [7:0] x, input logic [7:0] y, input logic c);
    int sx, sy, s;
    sx = int'(signed'(x));
    sy = int'(signed'(y));
    s  = sx + sy + int'(c);
    return (s > 127) || (s < -128);
  endfunction

  function automatic logic [2:0] ref2(input logic [1:0] x, input logic [1:0] y, input logic c);
    int s;
    s = int'(x) + int'(y) + int'(c);
    return 3'(s);
  endfunction

  function automatic logic ovf_ref2(input logic [1:0] x, input logic [1:0] y, input logic c);
    int s;
    s = int'(signed'(x)) + int'(signed'(y)) + int'(c);
    return (s > 1) || (s < -2);
  endfunction

  task automatic op8(input logic [7:0] aa, input logic [7:0] bb, input logic cc, input int hold);
    logic [8:0] r;
    int lat;
    r = ref8(aa, bb, cc);
    check("op8_accept_rdy", 32'(in_ready8), 32'(1));
    a8 = aa; b8 = bb; cin8 = cc; in_valid8 = 1'b1;
    tick();
    in_valid8 = 1'b0;
    a8 = 8'($urandom); b8 = 8'($urandom); cin8 = 1'($urandom);
    check("op8_run_flags", 32'({in_ready8, busy8, out_valid8}), 32'(3'b010));
    lat = 0;
    while (!out_valid8 && lat < 20) begin
      tick();
      lat++;
    end
    check("op8_latency", 32'(lat), 32'(4));
    check("op8_result", 32'({cout8, sum8}), 32'(r));
`ifdef SERIAL_ADD_OVF_EN
    check("op8_ovf", 32'(ovf8), 32'(ovf_ref8(aa, bb, cc)));
`endif
    for (int i = 0; i < hold; i++) begin
      in_valid8 = 1'b1;
      tick();
      check("op8_backpressure", 32'({out_valid8, in_ready8, cout8, sum8}), 32'({2'b10, r}));
    end
    in_valid8 = 1'b0;
    out_ready8 = 1'b1;
    tick();
    out_ready8 = 1'b0;
    check("op8_back_idle", 32'({in_ready8, out_valid8, busy8}), 32'(3'b100));
  endtask

  task automatic op2(input logic [1:0] aa, input logic [1:0] bb, input logic cc);
    logic [2:0] r;
    int lat;
    r = ref2(aa, bb, cc);
    check("op2_accept_rdy", 32'(in_ready2), 32'(1));
    a2 = aa; b2 = bb; cin2 = cc; in_valid2 = 1'b1;
    tick();
    in_valid2 = 1'b0;
    lat = 0;
    while (!out_valid2 && lat < 20) begin
      tick();
      lat++;
    end
    check("op2_latency", 32'(lat), 32'(1));
    check("op2_result", 32'({cout2, sum2}), 32'(r));
`ifdef SERIAL_ADD_OVF_EN
    check("op2_ovf", 32'(ovf2), 32'(ovf_ref2(aa, bb, cc)));
`endif
    out_ready2 = 1'b1;
    tick();
    out_ready2 = 1'b0;
    check("op2_back_idle", 32'({in_ready2, out_valid2, busy2}), 32'(3'b100));
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_w8"}, 32'({in_ready8, out_valid8, busy8, cout8, sum8}), 32'({3'b100, 9'h000}));
    check({tag, "_w2"}, 32'({in_ready2, out_valid2, busy2, cout2, sum2}), 32'({3'b100, 3'b000}));
`ifdef SERIAL_ADD_OVF_EN
    check({tag, "_ovf"}, 32'({ovf8, ovf2}), 32'(2'b00));
`endif
  endtask

  initial begin
    logic [8:0] q[$];
    logic [8:0] expv;
    int last_acc;
    logic acc;

    rst_n = 1'b0;
    in_valid8 = 1'b0; out_ready8 = 1'b0; a8 = '0; b8 = '0; cin8 = 1'b0;
    in_valid2 = 1'b0; out_ready2 = 1'b0; a2 = '0; b2 = '0; cin2 = 1'b0;
    #12;
    check_reset_vals("reset_state");
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    check_reset_vals("after_release");

    // Directed cases, second one with three cycles of backpressure.
    op8(8'hFF, 8'h01, 1'b0, 0);
    op8(8'h5A, 8'h33, 1'b1, 3);
    op8(8'h80, 8'h80, 1'b0, 1);
    op8(8'h7F, 8'h00, 1'b1, 0);

    for (int i = 0; i < 16; i++) begin
      op8(8'($urandom), 8'($urandom), 1'($urandom_range(0, 1)), int'($urandom_range(0, 3)));
    end

    // Reset in the middle of a run discards the operation.
    a8 = 8'hC3; b8 = 8'h9E; cin8 = 1'b1; in_valid8 = 1'b1;
    tick();
    in_valid8 = 1'b0;
    tick();
    tick();
    check("midrun_busy", 32'(busy8), 32'(1));
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_vals("midrun_reset");
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    check_reset_vals("midrun_release");
    op8(8'h10, 8'h20, 1'b0, 0);

    // WIDTH=2: every operand combination.
    for (int i = 0; i < 32; i++) begin
      logic [4:0] v;
      v = 5'(i);
      op2(v[4:3], v[2:1], v[0]);
    end

    // Back-to-back with in_valid and out_ready held high.
    q.delete();
    last_acc = -1;
    a8 = 8'($urandom); b8 = 8'($urandom); cin8 = 1'($urandom);
    in_valid8 = 1'b1;
    out_ready8 = 1'b1;
    for (int cyc = 0; cyc < 50; cyc++) begin
      if (cyc == 40) in_valid8 = 1'b0;
      if (out_valid8) begin
        check("b2b_expected_pending", 32'(q.size() > 0), 32'(1));
        if (q.size() > 0) begin
          expv = q.pop_front();
          check("b2b_result", 32'({cout8, sum8}), 32'(expv));
        end
      end
      acc = in_valid8 && in_ready8;
      if (acc) begin
        q.push_back(ref8(a8, b8, cin8));
        if (last_acc >= 0) check("b2b_interval", 32'(cyc - last_acc), 32'(6));
        last_acc = cyc;
      end
      tick();
      if (acc) begin
        a8 = 8'($urandom); b8 = 8'($urandom); cin8 = 1'($urandom);
      end
    end
    check("b2b_drained", 32'(q.size()), 32'(0));
    check("b2b_accept_count", 32'(last_acc), 32'(36));
    out_ready8 = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

endmodule
